// File: rtl/fml_bram_responder.sv
// FML slave endpoint backed by block RAM: one-cycle ack, fixed 4-beat 64-bit burst.
// Optional macro FML_BRAM_RANGE_CHECK_EN adds out-of-range detection and the range_err port.
module fml_bram_responder #(
  parameter int fml_depth   = 26,
  parameter int adr_width   = 9,
  parameter int wait_states = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [fml_depth-1:0] fml_adr,
  input  logic                 fml_stb,
  input  logic                 fml_we,
  output logic                 fml_ack,
  input  logic [7:0]           fml_sel,
  input  logic [63:0]          fml_di,
  output logic [63:0]          fml_do,
`ifdef FML_BRAM_RANGE_CHECK_EN
  output logic                 range_err,
`endif
  output logic                 busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WAIT   = 3'd1;
  localparam logic [2:0] ACK    = 3'd2;
  localparam logic [2:0] WBURST = 3'd3;
  localparam logic [2:0] RBURST = 3'd4;

  // Burst base is adr[adr_width+4:5]; each burst holds four 64-bit words.
  localparam int          word_width = adr_width + 2;
  localparam logic [3:0]  wait_load  = 4'(wait_states > 0 ? wait_states - 1 : 0);
  localparam logic [63:0] bad_data   = 64'hDEADBEEF_DEADBEEF;

  logic [2:0]            state;
  logic [3:0]            wait_cnt;
  logic [1:0]            beat;
  logic [adr_width-1:0]  base;
  logic                  we_q;
  logic                  rd_valid;
  logic                  oor_q;
  logic [63:0]           rd_q;
  logic [word_width-1:0] ram_addr;
  logic                  ram_we;
  logic [63:0]           mem [2**word_width];

`ifdef FML_BRAM_RANGE_CHECK_EN
  logic oor_req;
  logic unused_adr;

  assign oor_req    = |fml_adr[fml_depth-1:adr_width+5];
  assign unused_adr = ^fml_adr[4:0];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      oor_q     <= 1'b0;
      range_err <= 1'b0;
    end else if (state == IDLE && fml_stb) begin
      oor_q <= oor_req;
      if (oor_req) range_err <= 1'b1;
    end
  end
`else
  logic unused_adr;

  // High address bits are ignored, so the RAM aliases across the FML space.
  assign oor_q      = 1'b0;
  assign unused_adr = ^{fml_adr[fml_depth-1:adr_width+5], fml_adr[4:0]};
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      beat     <= 2'd0;
      base     <= '0;
      we_q     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fml_stb) begin
            base <= fml_adr[adr_width+4:5];
            we_q <= fml_we;
            beat <= 2'd0;
            if (wait_states > 0) begin
              wait_cnt <= wait_load;
              state    <= WAIT;
            end else begin
              state <= ACK;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= ACK;
          else wait_cnt <= wait_cnt - 4'd1;
        end
        ACK: begin
          if (we_q) begin
            beat  <= 2'd1;
            state <= WBURST;
          end else begin
            beat     <= 2'd0;
            rd_valid <= 1'b1;
            state    <= RBURST;
          end
        end
        WBURST: begin
          beat <= beat + 2'd1;
          if (beat == 2'd3) state <= IDLE;
        end
        RBURST: begin
          // rd_q is one beat behind the address, so the read address leads beat by one.
          beat <= beat + 2'd1;
          if (beat == 2'd3) state <= IDLE;
          else rd_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output of an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    ram_addr = {base, beat};
    if (state == RBURST) ram_addr = {base, beat + 2'd1};
  end

  assign ram_we = ((state == ACK && we_q) || state == WBURST) && !oor_q;

  // NOTE: the RAM array and its read register have no reset so they map onto block RAM.
  always_ff @(posedge sys_clk) begin
    if (ram_we) begin
      for (int i = 0; i < 8; i++) begin
        if (fml_sel[i]) mem[ram_addr][8*i +: 8] <= fml_di[8*i +: 8];
      end
    end
    rd_q <= mem[ram_addr];
  end

  assign fml_do  = rd_valid ? (oor_q ? bad_data : rd_q) : 64'd0;
  assign fml_ack = (state == ACK);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_fml_bram_responder.sv
// Bench for fml_bram_responder: table vectors, reset corner cases and random bursts
// checked against a word-array model; two instances cover wait_states 0 and 3.
module tb_fml_bram_responder;

  localparam logic [63:0] dead = 64'hDEADBEEF_DEADBEEF;
`ifdef FML_BRAM_RANGE_CHECK_EN
  localparam bit range_en = 1'b1;
`else
  localparam bit range_en = 1'b0;
`endif

  typedef logic [3:0][63:0] beats_t;
  typedef logic [3:0][7:0]  sels_t;
  typedef struct {
    logic        we;
    logic [25:0] adr;
    sels_t       sel;
    beats_t      di;
    beats_t      exp;
  } vec_t;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic [1:0]       stb_s, we_s, ack_s, busy_s;
  logic [1:0][25:0] adr_s;
  logic [1:0][7:0]  sel_s;
  logic [1:0][63:0] di_s, do_s;
`ifdef FML_BRAM_RANGE_CHECK_EN
  logic [1:0]       rerr_s;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] mdl [2][2048];

  always #5 sys_clk = ~sys_clk;

  fml_bram_responder #(.fml_depth(26), .adr_width(9), .wait_states(0)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .fml_adr(adr_s[0]), .fml_stb(stb_s[0]),
    .fml_we(we_s[0]), .fml_ack(ack_s[0]), .fml_sel(sel_s[0]), .fml_di(di_s[0]),
    .fml_do(do_s[0]),
`ifdef FML_BRAM_RANGE_CHECK_EN
    .range_err(rerr_s[0]),
`endif
    .busy(busy_s[0])
  );

  fml_bram_responder #(.fml_depth(26), .adr_width(9), .wait_states(3)) dut3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .fml_adr(adr_s[1]), .fml_stb(stb_s[1]),
    .fml_we(we_s[1]), .fml_ack(ack_s[1]), .fml_sel(sel_s[1]), .fml_di(di_s[1]),
    .fml_do(do_s[1]),
`ifdef FML_BRAM_RANGE_CHECK_EN
    .range_err(rerr_s[1]),
`endif
    .busy(busy_s[1])
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic sels_t mk_sel(input logic [7:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  function automatic beats_t mk_beats(input logic [63:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic oor(input logic [25:0] adr);
    return range_en && (|adr[25:14]);
  endfunction

  function automatic logic [10:0] widx(input logic [25:0] adr, input int b);
    return {adr[13:5], 2'(b)};
  endfunction

  task automatic model_write(input int d, input logic [25:0] adr, input sels_t sel,
                             input beats_t di);
    if (!oor(adr)) begin
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < 8; i++)
          if (sel[b][i]) mdl[d][widx(adr, b)][8*i +: 8] = di[b][8*i +: 8];
    end
  endtask

  function automatic beats_t model_read(input int d, input logic [25:0] adr);
    beats_t r;
    for (int b = 0; b < 4; b++) r[b] = oor(adr) ? dead : mdl[d][widx(adr, b)];
    return r;
  endfunction

  // Starts at a negedge with the DUT idle; ends at the negedge of the following idle cycle.
  task automatic burst(input int d, input logic we, input logic [25:0] adr, input sels_t sel,
                       input beats_t di, input int exp_lat, output beats_t got);
    int lat = 0;
    int nb;
    got = '0;
    nb  = we ? 3 : 4;
    stb_s[d] = 1'b1;
    we_s[d]  = we;
    adr_s[d] = adr;
    sel_s[d] = sel[0];
    di_s[d]  = di[0];
    do begin
      @(negedge sys_clk);
      lat++;
      if (!ack_s[d]) check("busy_wait", 64'(busy_s[d]), 64'd1);
    end while (!ack_s[d] && lat < 40);
    check("ack_latency", 64'(lat), 64'(exp_lat));
    stb_s[d] = 1'b0;
    check("busy_at_ack", 64'(busy_s[d]), 64'd1);
    check("do_at_ack", do_s[d], 64'd0);
    for (int b = 0; b < nb; b++) begin
      @(negedge sys_clk);
      if (b == 0) check("ack_one_cycle", 64'(ack_s[d]), 64'd0);
      check("busy_burst", 64'(busy_s[d]), 64'd1);
      if (we) begin
        sel_s[d] = sel[b+1];
        di_s[d]  = di[b+1];
      end else begin
        got[b] = do_s[d];
      end
    end
    @(negedge sys_clk);
    check("busy_idle", 64'(busy_s[d]), 64'd0);
    check("do_idle", do_s[d], 64'd0);
    check("ack_idle", 64'(ack_s[d]), 64'd0);
    sel_s[d] = 8'h00;
    di_s[d]  = {$urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [8];
    beats_t      got, exp, di;
    sels_t       sel;
    logic [25:0] adr;
    logic        we;
    logic [11:0] hi;
    int          idx;

    tbl[0] = '{1'b1, 26'h40, mk_sel(8'hFF, 8'hFF, 8'hFF, 8'hFF),
               mk_beats(64'h1111111111111111, 64'h2222222222222222,
                        64'h3333333333333333, 64'h4444444444444444), '0};
    tbl[1] = '{1'b0, 26'h40, '0, '0,
               mk_beats(64'h1111111111111111, 64'h2222222222222222,
                        64'h3333333333333333, 64'h4444444444444444)};
    tbl[2] = '{1'b1, 26'h0, mk_sel(8'hFF, 8'hFF, 8'hFF, 8'hFF), '0, '0};
    tbl[3] = '{1'b1, 26'h0, mk_sel(8'h0F, 8'h00, 8'h00, 8'h00),
               mk_beats(64'hFFFFFFFFFFFFFFFF, 64'hA5A5A5A5A5A5A5A5,
                        64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5), '0};
    tbl[4] = '{1'b0, 26'h0, '0, '0,
               mk_beats(64'h00000000FFFFFFFF, 64'h0, 64'h0, 64'h0)};
    tbl[5] = '{1'b1, 26'h60, mk_sel(8'hFF, 8'hFF, 8'hFF, 8'hFF),
               mk_beats(64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                        64'h0F0F0F0F0F0F0F0F, 64'hAAAAAAAAAAAAAAAA), '0};
    tbl[6] = '{1'b1, 26'h60, mk_sel(8'h3C, 8'h00, 8'hFF, 8'hC3),
               mk_beats(64'h5555555555555555, 64'h5555555555555555,
                        64'h5555555555555555, 64'h5555555555555555), '0};
    tbl[7] = '{1'b0, 26'h60, '0, '0,
               mk_beats(64'h01235555_5555CDEF, 64'hFEDCBA9876543210,
                        64'h5555555555555555, 64'h5555AAAA_AAAA5555)};

    stb_s = '0; we_s = '0; adr_s = '0; sel_s = '0; di_s = '0;
    sys_rst = 1'b1;
    #1;
    check("rst_ack", 64'(ack_s[0]), 64'd0);
    check("rst_do", do_s[0], 64'd0);
    check("rst_busy", 64'(busy_s[0]), 64'd0);
    check("rst_busy_ws3", 64'(busy_s[1]), 64'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    for (int i = 0; i < 8; i++) begin
      burst(0, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].di, 1, got);
      if (tbl[i].we) model_write(0, tbl[i].adr, tbl[i].sel, tbl[i].di);
      else for (int b = 0; b < 4; b++) check($sformatf("tbl%0d_b%0d", i, b), got[b], tbl[i].exp[b]);
    end

    // Reset while idle, applied between clock edges.
    #2 sys_rst = 1'b1;
    #1;
    check("idle_rst_busy", 64'(busy_s[0]), 64'd0);
    check("idle_rst_ack", 64'(ack_s[0]), 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Reset during a read burst, one beat in.
    exp = model_read(0, 26'h40);
    stb_s[0] = 1'b1; we_s[0] = 1'b0; adr_s[0] = 26'h40;
    @(negedge sys_clk);
    check("mrd_ack", 64'(ack_s[0]), 64'd1);
    stb_s[0] = 1'b0;
    @(posedge sys_clk);
    #2;
    check("mrd_beat0", do_s[0], exp[0]);
    sys_rst = 1'b1;
    #1;
    check("mrd_rst_do", do_s[0], 64'd0);
    check("mrd_rst_busy", 64'(busy_s[0]), 64'd0);
    check("mrd_rst_ack", 64'(ack_s[0]), 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Reset during a write burst after beats 0 and 1 are written.
    di = mk_beats(64'hC0C0C0C0C0C0C0C0, 64'hC1C1C1C1C1C1C1C1, 64'hC2C2C2C2C2C2C2C2, 64'hC3C3C3C3C3C3C3C3);
    sel = mk_sel(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    burst(0, 1'b1, 26'h80, sel, di, 1, got);
    model_write(0, 26'h80, sel, di);
    di = mk_beats(64'hD0D0D0D0D0D0D0D0, 64'hD1D1D1D1D1D1D1D1, 64'hD2D2D2D2D2D2D2D2, 64'hD3D3D3D3D3D3D3D3);
    stb_s[0] = 1'b1; we_s[0] = 1'b1; adr_s[0] = 26'h80; sel_s[0] = 8'hFF; di_s[0] = di[0];
    @(negedge sys_clk);
    check("mwr_ack", 64'(ack_s[0]), 64'd1);
    stb_s[0] = 1'b0;
    @(negedge sys_clk);
    di_s[0] = di[1];
    @(negedge sys_clk);
    di_s[0] = di[2];
    #1 sys_rst = 1'b1;
    #1;
    check("mwr_rst_busy", 64'(busy_s[0]), 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_write(0, 26'h80, mk_sel(8'hFF, 8'hFF, 8'h00, 8'h00), di);
    @(negedge sys_clk);
    foreach (exp[b]) exp[b] = model_read(0, 26'h80)[b];
    burst(0, 1'b0, 26'h80, '0, '0, 1, got);
    for (int b = 0; b < 4; b++) check($sformatf("mwr_keep_b%0d", b), got[b], exp[b]);
    exp = model_read(0, 26'h40);
    burst(0, 1'b0, 26'h40, '0, '0, 1, got);
    for (int b = 0; b < 4; b++) check($sformatf("rst_keep40_b%0d", b), got[b], exp[b]);

    // High address bits: alias onto word 0 by default, or flagged out of range.
`ifdef FML_BRAM_RANGE_CHECK_EN
    check("range_err_clear", 64'(rerr_s[0]), 64'd0);
`endif
    exp = model_read(0, 26'h4000);
    burst(0, 1'b0, 26'h4000, '0, '0, 1, got);
    for (int b = 0; b < 4; b++) check($sformatf("hi_rd_b%0d", b), got[b], exp[b]);
`ifdef FML_BRAM_RANGE_CHECK_EN
    check("range_err_set", 64'(rerr_s[0]), 64'd1);
`endif
    di = mk_beats(64'h7777777777777777, 64'h8888888888888888, 64'h9999999999999999, 64'hBBBBBBBBBBBBBBBB);
    sel = mk_sel(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    burst(0, 1'b1, 26'h4000, sel, di, 1, got);
    model_write(0, 26'h4000, sel, di);
    exp = model_read(0, 26'h0);
    burst(0, 1'b0, 26'h0, '0, '0, 1, got);
    for (int b = 0; b < 4; b++) check($sformatf("word0_b%0d", b), got[b], exp[b]);

    // Random traffic over bursts 16..23, preloaded with full writes.
    for (int k = 16; k < 24; k++) begin
      adr = 26'(k) << 5;
      for (int b = 0; b < 4; b++) di[b] = {$urandom, $urandom};
      sel = mk_sel(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      burst(0, 1'b1, adr, sel, di, 1, got);
      model_write(0, adr, sel, di);
    end
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(23, 16);
      hi  = ($urandom_range(3) == 0) ? 12'($urandom) : 12'h0;
      adr = {hi, 9'(idx), 5'($urandom)};
      we  = 1'($urandom);
      for (int b = 0; b < 4; b++) begin
        di[b] = {$urandom, $urandom};
        case ($urandom_range(2))
          0:       sel[b] = 8'hFF;
          1:       sel[b] = 8'h00;
          default: sel[b] = 8'($urandom);
        endcase
      end
      if (we) begin
        burst(0, 1'b1, adr, sel, di, 1, got);
        model_write(0, adr, sel, di);
      end else begin
        exp = model_read(0, adr);
        burst(0, 1'b0, adr, '0, '0, 1, got);
        for (int b = 0; b < 4; b++) check($sformatf("rnd%0d_b%0d", n, b), got[b], exp[b]);
      end
      repeat ($urandom_range(2)) @(negedge sys_clk);
    end

    // Three wait states: ack four cycles after the strobe is first seen.
    for (int b = 0; b < 4; b++) di[b] = {$urandom, $urandom};
    sel = mk_sel(8'hFF, 8'hF0, 8'h0F, 8'hFF);
    for (int b = 0; b < 4; b++) mdl[1][widx(26'h40, b)] = 64'h0;
    burst(1, 1'b1, 26'h40, mk_sel(8'hFF, 8'hFF, 8'hFF, 8'hFF), '0, 4, got);
    burst(1, 1'b1, 26'h40, sel, di, 4, got);
    model_write(1, 26'h40, sel, di);
    exp = model_read(1, 26'h40);
    burst(1, 1'b0, 26'h40, '0, '0, 4, got);
    for (int b = 0; b < 4; b++) check($sformatf("ws3_b%0d", b), got[b], exp[b]);
`ifdef FML_BRAM_RANGE_CHECK_EN
    check("ws3_range_err", 64'(rerr_s[1]), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
